// File: rtl/puf_crp_sequencer_if.sv
// Byte-stream / PUF-core signal bundle for the CRP sequencer.
// master = environment (UART + PUF core), slave = sequencer.
interface puf_crp_sequencer_if #(
  parameter int CHAL_BYTES = 8,
  parameter int RESP_BYTES = 4
);
  logic [7:0]              rx_data;
  logic                    rx_valid;
  logic [7:0]              tx_data;
  logic                    tx_valid;
  logic                    tx_ready;
  logic [CHAL_BYTES*8-1:0] puf_challenge;
  logic                    puf_start;
  logic                    puf_done;
  logic [RESP_BYTES*8-1:0] puf_response;

  modport master (
    output rx_data, rx_valid, tx_ready, puf_done, puf_response,
    input  tx_data, tx_valid, puf_challenge, puf_start
  );

  modport slave (
    input  rx_data, rx_valid, tx_ready, puf_done, puf_response,
    output tx_data, tx_valid, puf_challenge, puf_start
  );
endinterface

// File: rtl/puf_crp_sequencer.sv
// Frames UART bytes into a PUF challenge, runs one evaluation, returns the response LSB first.
// Optional WAIT timeout with error reply 8'hEE is enabled by defining CRP_TIMEOUT_EN.
module puf_crp_sequencer #(
  parameter int         CHAL_BYTES  = 8,
  parameter int         RESP_BYTES  = 4,
  parameter logic [7:0] CMD_BYTE    = 8'hA5,
  parameter int         TIMEOUT_CYC = 1024
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  puf_crp_sequencer_if.slave  bus,
  output logic                busy_o,
  output logic                err_o,
  output logic [2:0]          state_dbg_o
);
  localparam int MAXB = (CHAL_BYTES > RESP_BYTES) ? CHAL_BYTES : RESP_BYTES;
  localparam int CW   = $clog2(MAXB) + 1;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_RX    = 3'd1,
    S_START = 3'd2,
    S_WAIT  = 3'd3,
    S_TX    = 3'd4,
    S_ERR   = 3'd5
  } state_e;

  state_e                  state_q, state_d;
  logic [CW-1:0]           cnt_q, cnt_d;
  logic [CHAL_BYTES*8-1:0] chal_q, chal_d;
  logic [RESP_BYTES*8-1:0] resp_q, resp_d;
  logic                    err_q, err_d;
  logic                    tx_valid, puf_start;
  logic [7:0]              tx_data;

`ifdef CRP_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  logic [TW-1:0] tmo_q, tmo_d;
`endif

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      chal_q  <= '0;
      resp_q  <= '0;
      err_q   <= 1'b0;
`ifdef CRP_TIMEOUT_EN
      tmo_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      chal_q  <= chal_d;
      resp_q  <= resp_d;
      err_q   <= err_d;
`ifdef CRP_TIMEOUT_EN
      tmo_q   <= tmo_d;
`endif
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    chal_d    = chal_q;
    resp_d    = resp_q;
    err_d     = err_q;
    tx_valid  = 1'b0;
    tx_data   = 8'h00;
    puf_start = 1'b0;
`ifdef CRP_TIMEOUT_EN
    tmo_d     = tmo_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (bus.rx_valid && bus.rx_data == CMD_BYTE) begin
          state_d = S_RX;
          cnt_d   = '0;
          err_d   = 1'b0;
        end
      end
      // CMD_BYTE inside a frame is plain payload; no resync.
      S_RX: begin
        if (bus.rx_valid) begin
          chal_d[8*cnt_q +: 8] = bus.rx_data;
          if (cnt_q == CW'(CHAL_BYTES - 1)) state_d = S_START;
          else                              cnt_d   = cnt_q + 1'b1;
        end
      end
      S_START: begin
        puf_start = 1'b1;
        state_d   = S_WAIT;
`ifdef CRP_TIMEOUT_EN
        tmo_d     = '0;
`endif
      end
      // puf_done has priority over a timeout expiring in the same cycle.
      S_WAIT: begin
        if (bus.puf_done) begin
          resp_d  = bus.puf_response;
          cnt_d   = '0;
          state_d = S_TX;
        end
`ifdef CRP_TIMEOUT_EN
        else if (tmo_q == TW'(TIMEOUT_CYC - 1)) begin
          err_d   = 1'b1;
          state_d = S_ERR;
        end else begin
          tmo_d = tmo_q + 1'b1;
        end
`endif
      end
      S_TX: begin
        tx_valid = 1'b1;
        tx_data  = resp_q[8*cnt_q +: 8];
        if (bus.tx_ready) begin
          if (cnt_q == CW'(RESP_BYTES - 1)) begin
            state_d = S_IDLE;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      S_ERR: begin
        tx_valid = 1'b1;
        tx_data  = 8'hEE;
        if (bus.tx_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign bus.tx_valid      = tx_valid;
  assign bus.tx_data       = tx_data;
  assign bus.puf_start     = puf_start;
  assign bus.puf_challenge = chal_q;
  assign busy_o            = (state_q != S_IDLE);
  assign err_o             = err_q;
  assign state_dbg_o       = state_q;
endmodule

// File: tb/tb_puf_crp_sequencer.sv
// Directed table-driven bench for puf_crp_sequencer; timeout sequence depends on CRP_TIMEOUT_EN.
module tb_puf_crp_sequencer;
  logic       clk = 1'b0;
  logic       rst_n;
  logic       busy, err;
  logic [2:0] st_dbg;
  int         n_chk = 0;
  int         n_err = 0;

  always #5 clk = ~clk;

  puf_crp_sequencer_if #(.CHAL_BYTES(8), .RESP_BYTES(4)) bus ();

  puf_crp_sequencer #(
    .CHAL_BYTES(8), .RESP_BYTES(4), .CMD_BYTE(8'hA5), .TIMEOUT_CYC(16)
  ) dut (
    .clk_i(clk), .rst_ni(rst_n), .bus(bus),
    .busy_o(busy), .err_o(err), .state_dbg_o(st_dbg)
  );

  typedef struct {
    int          tn;
    logic        rst, rxv;
    logic [7:0]  rxd;
    logic        rdy, done;
    logic [31:0] resp;
    logic [2:0]  st;
    logic        tv;
    logic [7:0]  td;
    logic        ps;
    logic        cc;
    logic [63:0] chal;
  } vec_t;

  vec_t vq[$];

  function automatic void add(input int tn, input logic rst, input logic rxv,
                              input logic [7:0] rxd, input logic rdy, input logic done,
                              input logic [31:0] resp, input logic [2:0] st, input logic tv,
                              input logic [7:0] td, input logic ps);
    vec_t v;
    v.tn = tn; v.rst = rst; v.rxv = rxv; v.rxd = rxd; v.rdy = rdy; v.done = done;
    v.resp = resp; v.st = st; v.tv = tv; v.td = td; v.ps = ps; v.cc = 1'b0; v.chal = '0;
    vq.push_back(v);
  endfunction

  function automatic void chal_chk(input logic [63:0] c);
    vec_t v;
    v = vq.pop_back();
    v.cc = 1'b1;
    v.chal = c;
    vq.push_back(v);
  endfunction

  // A5 + 8 bytes b0..b0+7, then the START->WAIT cycle.
  function automatic void frame(input int tn, input logic [7:0] b0);
    add(tn, 1, 1, 8'hA5, 0, 0, 0, 3'd1, 0, 8'h00, 0);
    for (int i = 0; i < 7; i++) add(tn, 1, 1, b0 + 8'(i), 0, 0, 0, 3'd1, 0, 8'h00, 0);
    add(tn, 1, 1, b0 + 8'd7, 0, 0, 0, 3'd2, 0, 8'h00, 1);
    add(tn, 1, 0, 8'h00, 0, 0, 0, 3'd3, 0, 8'h00, 0);
  endfunction

  task automatic chk(input string nm, input int idx, input logic [63:0] act,
                     input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s @%0d: got %0h, expected %0h", nm, idx, act, exp);
    end
  endtask

  task automatic cyc(input logic rst, input logic rxv, input logic [7:0] rxd,
                     input logic rdy, input logic done, input logic [31:0] resp);
    @(negedge clk);
    rst_n = rst; bus.rx_valid = rxv; bus.rx_data = rxd;
    bus.tx_ready = rdy; bus.puf_done = done; bus.puf_response = resp;
    @(posedge clk);
    #1;
  endtask

  task automatic frame_seq(input logic [7:0] b0);
    cyc(1, 1, 8'hA5, 0, 0, 0);
    for (int i = 0; i < 8; i++) cyc(1, 1, b0 + 8'(i), 0, 0, 0);
    cyc(1, 0, 8'h00, 0, 0, 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0; bus.rx_valid = 0; bus.rx_data = 0; bus.tx_ready = 0;
    bus.puf_done = 0; bus.puf_response = 0;

    // t2: normal frame, response DEADBEEF after 5 WAIT cycles
    frame(2, 8'h01);
    chal_chk(64'h0807060504030201);
    for (int i = 0; i < 4; i++) add(2, 1, 0, 0, 0, 0, 0, 3'd3, 0, 8'h00, 0);
    add(2, 1, 0, 0, 0, 1, 32'hDEADBEEF, 3'd4, 1, 8'hEF, 0);
    add(2, 1, 0, 0, 1, 0, 0, 3'd4, 1, 8'hBE, 0);
    add(2, 1, 0, 0, 1, 0, 0, 3'd4, 1, 8'hAD, 0);
    add(2, 1, 0, 0, 1, 0, 0, 3'd4, 1, 8'hDE, 0);
    add(2, 1, 0, 0, 1, 0, 0, 3'd0, 0, 8'h00, 0);
    // t3: junk byte in IDLE, backpressure for 20 cycles
    add(3, 1, 1, 8'h3C, 0, 0, 0, 3'd0, 0, 8'h00, 0);
    frame(3, 8'h11);
    chal_chk(64'h1817161514131211);
    add(3, 1, 0, 0, 0, 1, 32'h44332211, 3'd4, 1, 8'h11, 0);
    for (int i = 0; i < 20; i++) add(3, 1, 0, 0, 0, 0, 0, 3'd4, 1, 8'h11, 0);
    add(3, 1, 0, 0, 1, 0, 0, 3'd4, 1, 8'h22, 0);
    add(3, 1, 0, 0, 1, 0, 0, 3'd4, 1, 8'h33, 0);
    add(3, 1, 0, 0, 1, 0, 0, 3'd4, 1, 8'h44, 0);
    add(3, 1, 0, 0, 1, 0, 0, 3'd0, 0, 8'h00, 0);
    // t4: rx bytes and spurious puf_done outside their accepting states
    frame(4, 8'h31);
    add(4, 1, 1, 8'hA5, 0, 0, 0, 3'd3, 0, 8'h00, 0);
    add(4, 1, 1, 8'h55, 0, 0, 0, 3'd3, 0, 8'h00, 0);
    chal_chk(64'h3837363534333231);
    add(4, 1, 0, 0, 0, 1, 32'hD4C3B2A1, 3'd4, 1, 8'hA1, 0);
    add(4, 1, 1, 8'hA5, 0, 0, 0, 3'd4, 1, 8'hA1, 0);
    add(4, 1, 0, 0, 0, 1, 32'hFFFFFFFF, 3'd4, 1, 8'hA1, 0);
    add(4, 1, 0, 0, 1, 1, 32'h00000000, 3'd4, 1, 8'hB2, 0);
    add(4, 1, 1, 8'h99, 1, 0, 0, 3'd4, 1, 8'hC3, 0);
    add(4, 1, 0, 0, 1, 0, 0, 3'd4, 1, 8'hD4, 0);
    add(4, 1, 0, 0, 1, 0, 0, 3'd0, 0, 8'h00, 0);
    add(4, 1, 0, 0, 0, 1, 32'h12345678, 3'd0, 0, 8'h00, 0);
    chal_chk(64'h3837363534333231);
    // t5: reset after 4 challenge bytes, then a full new frame
    add(5, 1, 1, 8'hA5, 0, 0, 0, 3'd1, 0, 8'h00, 0);
    for (int i = 0; i < 4; i++) add(5, 1, 1, 8'h41 + 8'(i), 0, 0, 0, 3'd1, 0, 8'h00, 0);
    add(5, 0, 0, 0, 0, 0, 0, 3'd0, 0, 8'h00, 0);
    chal_chk(64'h0);
    add(5, 1, 0, 0, 0, 0, 0, 3'd0, 0, 8'h00, 0);
    add(5, 1, 1, 8'h45, 0, 0, 0, 3'd0, 0, 8'h00, 0);
    frame(5, 8'h51);
    chal_chk(64'h5857565554535251);
    add(5, 1, 0, 0, 0, 1, 32'h87654321, 3'd4, 1, 8'h21, 0);
    add(5, 1, 0, 0, 1, 0, 0, 3'd4, 1, 8'h43, 0);
    add(5, 1, 0, 0, 1, 0, 0, 3'd4, 1, 8'h65, 0);
    add(5, 1, 0, 0, 1, 0, 0, 3'd4, 1, 8'h87, 0);
    add(5, 1, 0, 0, 1, 0, 0, 3'd0, 0, 8'h00, 0);

    // t1: reset held for 2 cycles
    cyc(0, 0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 0);
    chk("rst_state", 1, st_dbg, 3'd0);
    chk("rst_tx_valid", 1, bus.tx_valid, 1'b0);
    chk("rst_tx_data", 1, bus.tx_data, 8'h00);
    chk("rst_puf_start", 1, bus.puf_start, 1'b0);
    chk("rst_busy", 1, busy, 1'b0);
    chk("rst_err", 1, err, 1'b0);
    chk("rst_challenge", 1, bus.puf_challenge, 64'h0);

    foreach (vq[i]) begin
      cyc(vq[i].rst, vq[i].rxv, vq[i].rxd, vq[i].rdy, vq[i].done, vq[i].resp);
      chk($sformatf("t%0d_state", vq[i].tn), i, st_dbg, vq[i].st);
      chk($sformatf("t%0d_tx_valid", vq[i].tn), i, bus.tx_valid, vq[i].tv);
      chk($sformatf("t%0d_tx_data", vq[i].tn), i, bus.tx_data, vq[i].td);
      chk($sformatf("t%0d_puf_start", vq[i].tn), i, bus.puf_start, vq[i].ps);
      chk($sformatf("t%0d_busy", vq[i].tn), i, busy, vq[i].st != 3'd0);
      chk($sformatf("t%0d_err", vq[i].tn), i, err, 1'b0);
      if (vq[i].cc) chk($sformatf("t%0d_challenge", vq[i].tn), i, bus.puf_challenge, vq[i].chal);
    end

`ifdef CRP_TIMEOUT_EN
    // t6: 16 WAIT cycles without puf_done -> ERR, EE reply, sticky err
    frame_seq(8'h61);
    for (int i = 0; i < 15; i++) cyc(1, 0, 0, 0, 0, 0);
    chk("t6_wait_before_limit", 0, st_dbg, 3'd3);
    chk("t6_err_before_limit", 0, err, 1'b0);
    cyc(1, 0, 0, 0, 0, 0);
    chk("t6_err_state", 1, st_dbg, 3'd5);
    chk("t6_err_flag", 1, err, 1'b1);
    chk("t6_err_tx_valid", 1, bus.tx_valid, 1'b1);
    chk("t6_err_tx_data", 1, bus.tx_data, 8'hEE);
    chk("t6_err_busy", 1, busy, 1'b1);
    cyc(1, 0, 0, 0, 0, 0);
    chk("t6_err_hold", 2, bus.tx_data, 8'hEE);
    cyc(1, 0, 0, 1, 0, 0);
    chk("t6_idle_after_ee", 3, st_dbg, 3'd0);
    chk("t6_err_sticky", 3, err, 1'b1);
    cyc(1, 1, 8'h12, 0, 0, 0);
    chk("t6_err_sticky_junk", 4, err, 1'b1);
    cyc(1, 1, 8'hA5, 0, 0, 0);
    chk("t6_err_cleared", 5, err, 1'b0);
    chk("t6_rx_state", 5, st_dbg, 3'd1);
    // puf_done on the limit cycle wins
    for (int i = 0; i < 8; i++) cyc(1, 1, 8'h71 + 8'(i), 0, 0, 0);
    cyc(1, 0, 0, 0, 0, 0);
    for (int i = 0; i < 15; i++) cyc(1, 0, 0, 0, 0, 0);
    cyc(1, 0, 0, 0, 1, 32'hCAFEF00D);
    chk("t6_done_wins_state", 6, st_dbg, 3'd4);
    chk("t6_done_wins_data", 6, bus.tx_data, 8'h0D);
    chk("t6_done_wins_err", 6, err, 1'b0);
    for (int i = 0; i < 4; i++) cyc(1, 0, 0, 1, 0, 0);
    chk("t6_drain_idle", 7, st_dbg, 3'd0);
`else
    // t6: without the timeout option WAIT never gives up
    frame_seq(8'h61);
    for (int i = 0; i < 40; i++) cyc(1, 0, 0, 0, 0, 0);
    chk("t6_wait_forever", 0, st_dbg, 3'd3);
    chk("t6_err_tied", 0, err, 1'b0);
    cyc(1, 0, 0, 0, 1, 32'hCAFEF00D);
    chk("t6_late_done_state", 1, st_dbg, 3'd4);
    chk("t6_late_done_data", 1, bus.tx_data, 8'h0D);
    for (int i = 0; i < 4; i++) cyc(1, 0, 0, 1, 0, 0);
    chk("t6_drain_idle", 2, st_dbg, 3'd0);
`endif

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
